lane_permute_switch: RTL

//  N-lane generalisation of the FHE ALU buffer-RAM port swap.

---
 rtl/lane_permute_switch.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lane_permute_switch.sv
// ---------------------------------------------------------------------------
// lane_permute_switch
//
// Purpose
//   Routes NUM_LANES data lanes from the buffer RAM read ports to the ALU
//   operand inputs through a programmable permutation/broadcast map:
//   output lane j takes input lane sel[j]. Duplicate selectors are legal and
//   give a broadcast.
//
//   The map is double-buffered. A new map lands in a pending slot and becomes
//   the active map only at a frame boundary. A map never changes in the middle
//   of a frame. Each beat captures the active map when it is accepted and
//   carries it down the pipe, so a beat always leaves with the map it came in
//   with.
//
//   The data path is a two-stage elastic valid/ready pipe with full
//   backpressure:
//     S1 holds {data, last, map}.
//     S2 holds the permuted result.
//   Latency is 2 cycles and throughput is 1 beat per cycle.
//
// Ports
//   clk        clock
//   rst_n      asynchronous, active-low reset
//   cfg_valid  a new map is offered on cfg_sel
//   cfg_sel    map; field j (bits j*SEL_W +: SEL_W) = source lane of out lane j
//   cfg_ready  pending map slot is empty
//   in_valid   input beat valid
//   in_last    input beat is the last of its frame
//   in_data    input lanes, lane i at bits i*DATA_W +: DATA_W
//   in_ready   input beat is taken when in_valid && in_ready
//   out_valid  output beat valid
//   out_last   in_last carried along with the beat
//   out_data   permuted lanes, lane j at bits j*DATA_W +: DATA_W
//   out_ready  downstream accepts the output beat
//   cfg_err    sticky; a selector >= NUM_LANES has been applied to a beat
// ---------------------------------------------------------------------------
module lane_permute_switch #(
    parameter  int NUM_LANES = 4,
    parameter  int DATA_W    = 64,
    localparam int SEL_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic                          cfg_valid,
    input  logic [NUM_LANES*SEL_W-1:0]    cfg_sel,
    output logic                          cfg_ready,

    input  logic                          in_valid,
    input  logic                          in_last,
    input  logic [NUM_LANES*DATA_W-1:0]   in_data,
    output logic                          in_ready,

    output logic                          out_valid,
    output logic                          out_last,
    output logic [NUM_LANES*DATA_W-1:0]   out_data,
    input  logic                          out_ready,

    output logic                          cfg_err
);

    localparam int MAP_W = NUM_LANES * SEL_W;
    localparam int BUS_W = NUM_LANES * DATA_W;

    // Identity map: sel[j] = j. This is the active map after reset.
    function automatic logic [MAP_W-1:0] identity_map();
        logic [MAP_W-1:0] m;
        m = '0;
        for (int j = 0; j < NUM_LANES; j++) begin
            m[j*SEL_W +: SEL_W] = SEL_W'(j);
        end
        return m;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [MAP_W-1:0] active_map_reg;
    logic [MAP_W-1:0] pend_map_reg;
    logic             pend_full_reg;
    logic             in_frame_reg;

    logic             s1_valid_reg;
    logic             s1_last_reg;
    logic [BUS_W-1:0] s1_data_reg;
    logic [MAP_W-1:0] s1_map_reg;

    logic             s2_valid_reg;
    logic             s2_last_reg;
    logic [BUS_W-1:0] s2_data_reg;

    logic             cfg_err_reg;

    // -----------------------------------------------------------------------
    // Handshake and control
    // -----------------------------------------------------------------------
    logic s2_advance;
    logic in_ready_int;
    logic beat_accept;
    logic cfg_accept;
    logic map_switch;

    // S2 can take a new value when it is empty or is being drained this
    // cycle. S1 can take a new beat when it is empty or is moving into S2.
    assign s2_advance   = !s2_valid_reg || out_ready;
    assign in_ready_int = !s1_valid_reg || s2_advance;
    assign beat_accept  = in_valid && in_ready_int;
    assign cfg_accept   = cfg_valid && !pend_full_reg;

    // The pending map is promoted in two situations:
    //   - between frames, on a cycle when no beat is accepted, or
    //   - on the cycle the last beat of a frame is accepted.
    // In the second case the last beat still captures the old active map,
    // because S1 samples active_map_reg before this edge updates it.
    // cfg_accept needs an empty slot and map_switch needs a full one, so a
    // map loaded this cycle is never promoted in the same cycle.
    assign map_switch = pend_full_reg &&
                        ((!in_frame_reg && !beat_accept) ||
                         (beat_accept && in_last));

    // -----------------------------------------------------------------------
    // Lane crossbar, driven from the S1 map
    // -----------------------------------------------------------------------
    logic [BUS_W-1:0]     perm_data;
    logic [NUM_LANES-1:0] lane_range_err;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [SEL_W-1:0]  lane_sel;
            logic [DATA_W-1:0] lane_out;
            logic              lane_err;

            assign lane_sel = s1_map_reg[gi*SEL_W +: SEL_W];

            // One-hot compare mux over the legal sources. A selector that
            // matches no lane (only possible when NUM_LANES is not a power
            // of two) gives zero data and raises the range flag.
            always_comb begin
                lane_out = '0;
                lane_err = 1'b1;
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (lane_sel == SEL_W'(i)) begin
                        lane_out = s1_data_reg[i*DATA_W +: DATA_W];
                        lane_err = 1'b0;
                    end
                end
            end

            assign perm_data[gi*DATA_W +: DATA_W] = lane_out;
            assign lane_range_err[gi]             = lane_err;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Map double buffer and frame tracking
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_map_reg <= identity_map();
            pend_map_reg   <= '0;
            pend_full_reg  <= 1'b0;
        end else begin
            if (cfg_accept) begin
                pend_map_reg  <= cfg_sel;
                pend_full_reg <= 1'b1;
            end else if (map_switch) begin
                active_map_reg <= pend_map_reg;
                pend_full_reg  <= 1'b0;
            end
        end
    end

    // in_frame is set by a non-last beat and cleared by a last beat. A
    // one-beat frame therefore leaves it clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_frame_reg <= 1'b0;
        end else if (beat_accept) begin
            in_frame_reg <= !in_last;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1: accepted beat together with the map that was active for it
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_data_reg  <= '0;
            s1_map_reg   <= identity_map();
        end else if (in_ready_int) begin
            s1_valid_reg <= beat_accept;
            if (beat_accept) begin
                s1_last_reg <= in_last;
                s1_data_reg <= in_data;
                s1_map_reg  <= active_map_reg;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: output register. It is loaded only on advance, so out_* stay
    // stable while downstream stalls.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_last_reg  <= 1'b0;
            s2_data_reg  <= '0;
        end else if (s2_advance) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_last_reg <= s1_last_reg;
                s2_data_reg <= perm_data;
            end
        end
    end

    // Sticky range error. It is raised only when a bad selector is actually
    // applied to a beat moving from S1 to S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_reg <= 1'b0;
        end else if (s2_advance && s1_valid_reg && (|lane_range_err)) begin
            cfg_err_reg <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign cfg_ready = !pend_full_reg;
    assign in_ready  = in_ready_int;
    assign out_valid = s2_valid_reg;
    assign out_last  = s2_last_reg;
    assign out_data  = s2_data_reg;
    assign cfg_err   = cfg_err_reg;

endmodule
